egress_drain: RTL and testbench
===============================

// Module: egress_drain
// PURPOSE
//  Consumer end of the QoS path: drains destination FIFOs D0 and D1 and merges them into one output stream.
//  Replaces the bench-driven D0_rd/D1_rd.
//  Arbitrates between the two FIFOs and honours FIFO read latency.
//  Holds output under backpressure without loss and counts delivered words per destination.
// PARAMETERS
//  BW   6  data word width, matching D0_data_out/D1_data_out
//  CW   5  width of per-destination delivered-word counters
// PORTS
//  clk              in   1   single clock, all logic on posedge
//  reset_L          in   1   synchronous active-low reset
//  init             in   1   synchronous restart: same effect as reset, one cycle pulse
//  D0_empty         in   1   D0 FIFO empty
//  D1_empty         in   1   D1 FIFO empty
//  D0_error_output  in   1   D0 FIFO read-underflow error
//  D1_error_output  in   1   D1 FIFO read-underflow error
//  D0_data_out      in   BW  D0 read data, valid 1 cycle after D0_rd
//  D1_data_out      in   BW  D1 read data, valid 1 cycle after D1_rd
//  D0_weight        in   4   WRR weight for D0 (used only with macro)
//  D1_weight        in   4   WRR weight for D1 (used only with macro)
//  out_ready        in   1   downstream accepts out_data this cycle
//  D0_rd            out  1   pop D0
//  D1_rd            out  1   pop D1
//  out_data         out  BW  head-of-buffer word
//  out_src          out  1   0 = word came from D0, 1 = from D1
//  out_valid        out  1   out_data valid; transfer when out_valid & out_ready
//  cnt_D0           out  CW  words delivered from D0 (wraps)
//  cnt_D1           out  CW  words delivered from D1 (wraps)
//  error_out        out  1   sticky: FIFO error flag seen
//  idle_out         out  1   both FIFOs empty, buffer empty, nothing in flight
// BEHAVIOUR
//  Reset/init (reset_L=0 or init=1 at posedge):
//   - All outputs 0 except idle_out=1. Buffer cleared, in-flight read discarded.
//   - RR pointer -> D0; state -> IDLE.
//  Output buffer: 2-entry FIFO of {src,data}.
//   - out_valid = occupancy != 0.
//   - out_data/out_src are the head entry.
//  Read issue: at most one of D0_rd/D1_rd high per cycle. Issue only when (occupancy + inflight) < 2,
//   so no word is ever dropped. Data is captured the cycle after rd using the registered src tag.
//  Simultaneous pop (out_valid & out_ready) and capture in one cycle:
//   - Occupancy unchanged; order preserved.
//  Arbitration (no macro): strict alternation among non-empty FIFOs.
//   - Pointer toggles after each grant; an empty FIFO is skipped.
//   - Both non-empty, pointer=D0 -> D0, then D1, ...
//  D0_rd/D1_rd are combinational from registered state. They are never asserted when the FIFO's empty=1.
//  State machine:
//   - IDLE: nothing buffered or in flight. -> RUN when any FIFO is non-empty.
//   - RUN: issue reads per rules. -> IDLE when both empty, occupancy=0 and inflight=0.
//   - HALT: entered from any state when D0_error_output|D1_error_output=1. No further rd.
//     Buffer still drains to downstream. error_out=1.
//     HALT is left only by reset/init.
//  Counters: cnt_Dn increments on transfer (out_valid & out_ready & out_src==n). Wraps 2^CW-1 -> 0.
//  idle_out = (state==IDLE), registered.
// CONFIGURATION
//  EGRESS_WRR_EN defined:
//   - Weighted round robin: the current FIFO keeps grant for up to its weight consecutive reads.
//   - Grant moves early if the current FIFO becomes empty.
//   - Weight 0 is treated as 1.
//   - Weights are sampled when the grant switches.
//  EGRESS_WRR_EN undefined:
//   - D0_weight/D1_weight are ignored; strict alternation as above.
// TESTING
//  1 Reset: reset_L=0 for 2 cycles -> all outputs 0, idle_out=1. init pulse mid-stream -> same, buffer flushed.
//  2 D0 holds 0x01,0x0F,0x0C; D1 empty; out_ready=1 -> D0_rd 3 cycles.
//    out_data 0x01,0x0F,0x0C, out_src=0, cnt_D0=3.
//  3 D0 and D1 each hold 4 words, out_ready=1 -> reads alternate D0,D1,D0,D1...
//    Output order matches; cnt_D0=cnt_D1=4; idle_out returns to 1.
//  4 out_ready=0 with FIFOs non-empty -> at most 2 words buffered, then rd stays 0.
//    Release -> no word lost or duplicated.
//  5 Assert D1_error_output=1 mid-stream -> error_out=1 next cycle, no further rd.
//    Buffered words still drain; state held until init.
//  6 EGRESS_WRR_EN, D0_weight=3, D1_weight=1, both FIFOs deep -> grant pattern D0,D0,D0,D1 repeating.
//    Cnt wraps at 32 after 32 D0 words.

Source files
------------

// File: rtl/egress_drain_if.sv
// Bundle of FIFO-side, configuration, output-stream and status signals for egress_drain.
// The master modport is the drain itself; the slave modport is the FIFOs plus the downstream consumer.
interface egress_drain_if #(
    parameter int BW = 6,
    parameter int CW = 5
);
    logic          D0_empty;
    logic          D1_empty;
    logic          D0_error_output;
    logic          D1_error_output;
    logic [BW-1:0] D0_data_out;
    logic [BW-1:0] D1_data_out;
    logic [3:0]    D0_weight;
    logic [3:0]    D1_weight;
    logic          out_ready;
    logic          D0_rd;
    logic          D1_rd;
    logic [BW-1:0] out_data;
    logic          out_src;
    logic          out_valid;
    logic [CW-1:0] cnt_D0;
    logic [CW-1:0] cnt_D1;
    logic          error_out;
    logic          idle_out;

    modport master (
        input  D0_empty, D1_empty, D0_error_output, D1_error_output,
        input  D0_data_out, D1_data_out, D0_weight, D1_weight, out_ready,
        output D0_rd, D1_rd, out_data, out_src, out_valid,
        output cnt_D0, cnt_D1, error_out, idle_out
    );

    modport slave (
        output D0_empty, D1_empty, D0_error_output, D1_error_output,
        output D0_data_out, D1_data_out, D0_weight, D1_weight, out_ready,
        input  D0_rd, D1_rd, out_data, out_src, out_valid,
        input  cnt_D0, cnt_D1, error_out, idle_out
    );
endinterface

// File: rtl/egress_drain.sv
// Drains destination FIFOs D0/D1 into one output stream through a 2-entry skid buffer.
// Define EGRESS_WRR_EN for weighted round robin; otherwise strict alternation between non-empty FIFOs.
module egress_drain #(
    parameter int BW = 6,
    parameter int CW = 5
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic              init,
    egress_drain_if.master    bus
);
    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

    typedef struct packed {
        logic          src;
        logic [BW-1:0] data;
    } entry_t;

    state_t        state;
    logic          error_q;
    logic          idle_q;
    logic          clear;

    entry_t        buf_mem [2];
    logic          head;
    logic          tail;
    logic [1:0]    occ;
    logic          inflight;
    logic          inflight_src;
    logic [CW-1:0] cnt0;
    logic [CW-1:0] cnt1;

    logic          ptr;
    logic          ne_ptr;
    logic          ne_other;
    logic          keep;
    logic          sel;
    logic          can_issue;
    logic          grant;
    logic          pop;
    logic          err_in;
    entry_t        head_entry;
    entry_t        cap_entry;

    assign clear  = ~reset_L | init;
    assign err_in = bus.D0_error_output | bus.D1_error_output;

    // Occupancy plus the outstanding read never exceeds the two buffer slots.
    assign can_issue = (state == RUN) && ((occ + {1'b0, inflight}) < 2'd2);

    assign ne_ptr   = ptr ? ~bus.D1_empty : ~bus.D0_empty;
    assign ne_other = ptr ? ~bus.D0_empty : ~bus.D1_empty;

`ifdef EGRESS_WRR_EN
    logic [3:0] burst;
    logic [3:0] wlim;

    function automatic logic [3:0] eff_weight(input logic [3:0] w);
        return (w == 4'd0) ? 4'd1 : w;
    endfunction

    // burst==0 means the current weight has not been sampled yet (fresh after reset).
    assign keep = ne_ptr && ((burst == 4'd0) || (burst < wlim));
`else
    logic unused_weights;
    assign unused_weights = ^{bus.D0_weight, bus.D1_weight};
    assign keep = ne_ptr;
`endif

    always_comb begin
        // NOTE: every signal written here gets a default first so no latch is inferred.
        sel = ptr;
        if (!keep && ne_other) begin
            sel = ~ptr;
        end
    end

    assign grant     = can_issue && (sel ? ~bus.D1_empty : ~bus.D0_empty);
    assign bus.D0_rd = grant & ~sel;
    assign bus.D1_rd = grant &  sel;

    assign head_entry    = buf_mem[head];
    assign pop           = (occ != 2'd0) && bus.out_ready;
    assign cap_entry.src  = inflight_src;
    assign cap_entry.data = inflight_src ? bus.D1_data_out : bus.D0_data_out;

    assign bus.out_valid = (occ != 2'd0);
    assign bus.out_data  = bus.out_valid ? head_entry.data : '0;
    assign bus.out_src   = bus.out_valid ? head_entry.src  : 1'b0;
    assign bus.cnt_D0    = cnt0;
    assign bus.cnt_D1    = cnt1;
    assign bus.error_out = error_q;
    assign bus.idle_out  = idle_q;

    // NOTE: buffer storage is not reset; occupancy gates its visibility, so stale contents never escape.
    always_ff @(posedge clk) begin
        if (inflight) begin
            buf_mem[tail] <= cap_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            head         <= 1'b0;
            tail         <= 1'b0;
            occ          <= 2'd0;
            inflight     <= 1'b0;
            inflight_src <= 1'b0;
            cnt0         <= '0;
            cnt1         <= '0;
        end else begin
            inflight     <= grant;
            inflight_src <= sel;
            if (inflight) begin
                tail <= ~tail;
            end
            if (pop) begin
                head <= ~head;
                if (head_entry.src) begin
                    cnt1 <= cnt1 + 1'b1;
                end else begin
                    cnt0 <= cnt0 + 1'b1;
                end
            end
            unique case ({inflight, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

`ifdef EGRESS_WRR_EN
    always_ff @(posedge clk) begin
        if (clear) begin
            ptr   <= 1'b0;
            burst <= 4'd0;
            wlim  <= 4'd1;
        end else if (grant) begin
            if ((sel == ptr) && (burst != 4'd0) && (burst < wlim)) begin
                burst <= burst + 4'd1;
            end else begin
                // Grant switches (or restarts after an exhausted burst): sample the new weight.
                ptr   <= sel;
                burst <= 4'd1;
                wlim  <= eff_weight(sel ? bus.D1_weight : bus.D0_weight);
            end
        end
    end
`else
    always_ff @(posedge clk) begin
        if (clear) begin
            ptr <= 1'b0;
        end else if (grant) begin
            ptr <= ~sel;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (clear) begin
            state   <= IDLE;
            error_q <= 1'b0;
            idle_q  <= 1'b1;
        end else if (err_in) begin
            state   <= HALT;
            error_q <= 1'b1;
            idle_q  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (~bus.D0_empty | ~bus.D1_empty) begin
                        state  <= RUN;
                        idle_q <= 1'b0;
                    end
                end
                RUN: begin
                    if (bus.D0_empty && bus.D1_empty && (occ == 2'd0) && !inflight) begin
                        state  <= IDLE;
                        idle_q <= 1'b1;
                    end
                end
                HALT: begin
                    state <= HALT;
                end
                default: begin
                    state  <= IDLE;
                    idle_q <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_egress_drain.sv
// Directed bench for egress_drain: behavioural FIFOs with 1-cycle read latency, a transfer/grant
// logger, and hand-computed expectations for reset, alternation, backpressure, halt, init and wrap.
module tb_egress_drain;
    localparam int BW = 6;
    localparam int CW = 5;

    logic clk = 1'b0;
    logic reset_L;
    logic init;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    egress_drain_if #(.BW(BW), .CW(CW)) bus ();

    egress_drain #(.BW(BW), .CW(CW)) dut (
        .clk     (clk),
        .reset_L (reset_L),
        .init    (init),
        .bus     (bus)
    );

    logic [BW-1:0] mem0 [128];
    logic [BW-1:0] mem1 [128];
    int            n0 = 0;
    int            n1 = 0;
    int            rp0 = 0;
    int            rp1 = 0;
    logic [BW-1:0] d0_q = '0;
    logic [BW-1:0] d1_q = '0;

    assign bus.D0_empty    = (rp0 >= n0);
    assign bus.D1_empty    = (rp1 >= n1);
    assign bus.D0_data_out = d0_q;
    assign bus.D1_data_out = d1_q;

    always @(posedge clk) begin
        if (bus.D0_rd) begin
            d0_q <= mem0[rp0 & 127];
            rp0  <= rp0 + 1;
        end
        if (bus.D1_rd) begin
            d1_q <= mem1[rp1 & 127];
            rp1  <= rp1 + 1;
        end
    end

    logic [6:0] rx_q [$];
    bit         grant_q [$];

    always @(posedge clk) begin
        if (bus.D0_rd) grant_q.push_back(1'b0);
        if (bus.D1_rd) grant_q.push_back(1'b1);
        if (bus.out_valid && bus.out_ready) rx_q.push_back({bus.out_src, bus.out_data});
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push0(input logic [BW-1:0] v);
        mem0[n0 & 127] = v;
        n0++;
    endtask

    task automatic push1(input logic [BW-1:0] v);
        mem1[n1 & 127] = v;
        n1++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_L = 1'b0;
        repeat (2) @(negedge clk);
        reset_L = 1'b1;
    endtask

    task automatic pulse_init();
        @(negedge clk);
        init = 1'b1;
        @(negedge clk);
        init = 1'b0;
    endtask

    task automatic run_idle(input string tag, input int max_cycles);
        bit done = 1'b0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < max_cycles; k++) begin
            if (bus.idle_out && (rp0 >= n0) && (rp1 >= n1)) begin
                done = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check({tag, " done"}, 32'(done), 32'd1);
    endtask

    task automatic check_rx(input string tag, input int base, input logic [6:0] exp[$]);
        check({tag, " rx_count"}, rx_q.size() - base, exp.size());
        for (int i = 0; i < exp.size(); i++) begin
            logic [6:0] obs;
            obs = (base + i < rx_q.size()) ? rx_q[base + i] : 7'bx;
            check($sformatf("%s rx[%0d]", tag, i), 32'(obs), 32'(exp[i]));
        end
    endtask

    task automatic check_grants(input string tag, input int base, input bit exp[$]);
        check({tag, " grant_count"}, grant_q.size() - base, exp.size());
        for (int i = 0; i < exp.size(); i++) begin
            logic obs;
            obs = (base + i < grant_q.size()) ? grant_q[base + i] : 1'bx;
            check($sformatf("%s grant[%0d]", tag, i), 32'(obs), 32'(exp[i]));
        end
    endtask

    initial begin
        logic [6:0] erx[$];
        bit         egr[$];
        int         rb;
        int         gb;

        reset_L             = 1'b0;
        init                = 1'b0;
        bus.out_ready       = 1'b0;
        bus.D0_error_output = 1'b0;
        bus.D1_error_output = 1'b0;
        bus.D0_weight       = 4'd0;
        bus.D1_weight       = 4'd0;

        // Reset state
        do_reset();
        @(negedge clk);
        check("rst idle_out", bus.idle_out, 1);
        check("rst out_valid", bus.out_valid, 0);
        check("rst out_data", bus.out_data, 0);
        check("rst out_src", bus.out_src, 0);
        check("rst cnt_D0", bus.cnt_D0, 0);
        check("rst cnt_D1", bus.cnt_D1, 0);
        check("rst error_out", bus.error_out, 0);
        check("rst D0_rd", bus.D0_rd, 0);
        check("rst D1_rd", bus.D1_rd, 0);

        // D0 only, three words
        rb = rx_q.size(); gb = grant_q.size();
        bus.out_ready = 1'b1;
        push0(6'h01); push0(6'h0F); push0(6'h0C);
        run_idle("d0only", 40);
        erx = '{7'h01, 7'h0F, 7'h0C};
        check_rx("d0only", rb, erx);
        egr = '{1'b0, 1'b0, 1'b0};
        check_grants("d0only", gb, egr);
        check("d0only cnt_D0", bus.cnt_D0, 3);
        check("d0only cnt_D1", bus.cnt_D1, 0);

        // Both FIFOs with four words: strict alternation
        do_reset();
        rb = rx_q.size(); gb = grant_q.size();
        for (int i = 0; i < 4; i++) begin
            push0(6'(6'h10 + i));
            push1(6'(6'h20 + i));
        end
        run_idle("alt", 60);
        erx = '{7'h10, 7'h60, 7'h11, 7'h61, 7'h12, 7'h62, 7'h13, 7'h63};
        check_rx("alt", rb, erx);
        egr = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        check_grants("alt", gb, egr);
        check("alt cnt_D0", bus.cnt_D0, 4);
        check("alt cnt_D1", bus.cnt_D1, 4);
        check("alt idle_out", bus.idle_out, 1);

        // Backpressure: buffer fills to two, reads stop, release loses nothing
        do_reset();
        rb = rx_q.size(); gb = grant_q.size();
        bus.out_ready = 1'b0;
        push0(6'h31); push0(6'h32); push0(6'h33);
        push1(6'h05); push1(6'h06); push1(6'h07);
        repeat (8) @(negedge clk);
        check("bp grants_held", grant_q.size() - gb, 2);
        check("bp out_valid", bus.out_valid, 1);
        check("bp head_data", bus.out_data, 6'h31);
        check("bp head_src", bus.out_src, 0);
        check("bp D0_rd", bus.D0_rd, 0);
        check("bp D1_rd", bus.D1_rd, 0);
        bus.out_ready = 1'b1;
        run_idle("bp", 60);
        erx = '{7'h31, 7'h45, 7'h32, 7'h46, 7'h33, 7'h47};
        check_rx("bp", rb, erx);
        check("bp cnt_D0", bus.cnt_D0, 3);
        check("bp cnt_D1", bus.cnt_D1, 3);

        // init mid-stream flushes the buffer; the two buffered words are never delivered
        do_reset();
        rb = rx_q.size(); gb = grant_q.size();
        bus.out_ready = 1'b0;
        push0(6'h0A); push0(6'h0B); push0(6'h0C);
        push1(6'h1A); push1(6'h1B); push1(6'h1C);
        repeat (8) @(negedge clk);
        check("init pre out_valid", bus.out_valid, 1);
        pulse_init();
        check("init out_valid", bus.out_valid, 0);
        check("init idle_out", bus.idle_out, 1);
        check("init out_data", bus.out_data, 0);
        bus.out_ready = 1'b1;
        run_idle("init", 60);
        erx = '{7'h0B, 7'h5B, 7'h0C, 7'h5C};
        check_rx("init", rb, erx);
        check("init cnt_D0", bus.cnt_D0, 2);
        check("init cnt_D1", bus.cnt_D1, 2);

        // Error halts reads, buffer still drains, held until init
        do_reset();
        rb = rx_q.size(); gb = grant_q.size();
        bus.out_ready = 1'b0;
        push0(6'h21); push0(6'h22); push0(6'h23); push0(6'h24);
        push1(6'h11); push1(6'h12); push1(6'h13); push1(6'h14);
        repeat (8) @(negedge clk);
        bus.D1_error_output = 1'b1;
        @(negedge clk);
        bus.D1_error_output = 1'b0;
        check("halt error_out", bus.error_out, 1);
        check("halt idle_out", bus.idle_out, 0);
        check("halt D0_rd", bus.D0_rd, 0);
        check("halt D1_rd", bus.D1_rd, 0);
        bus.out_ready = 1'b1;
        repeat (8) @(negedge clk);
        erx = '{7'h21, 7'h51};
        check_rx("halt", rb, erx);
        check("halt grants", grant_q.size() - gb, 2);
        check("halt drained", bus.out_valid, 0);
        check("halt error_sticky", bus.error_out, 1);
        check("halt cnt_D0", bus.cnt_D0, 1);
        check("halt cnt_D1", bus.cnt_D1, 1);
        n0 = rp0;
        n1 = rp1;
        pulse_init();
        check("halt init error_out", bus.error_out, 0);
        check("halt init idle_out", bus.idle_out, 1);

        // Counter wrap: 33 D0 words -> cnt_D0 = 1
        do_reset();
        rb = rx_q.size();
        for (int i = 0; i < 33; i++) push0(6'(i));
        run_idle("wrap", 200);
        check("wrap rx_count", rx_q.size() - rb, 33);
        check("wrap last", (rx_q.size() > 0) ? rx_q[rx_q.size() - 1] : 7'bx, 7'h20);
        check("wrap cnt_D0", bus.cnt_D0, 1);
        check("wrap cnt_D1", bus.cnt_D1, 0);

        // Weights 3/1: WRR pattern when enabled, otherwise ignored
        do_reset();
        gb = grant_q.size();
        bus.D0_weight = 4'd3;
        bus.D1_weight = 4'd1;
        for (int i = 0; i < 6; i++) push0(6'(i + 1));
        push1(6'h31); push1(6'h32);
        run_idle("wrr", 80);
`ifdef EGRESS_WRR_EN
        egr = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
`else
        egr = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
        check_grants("wrr", gb, egr);
        check("wrr cnt_D0", bus.cnt_D0, 6);
        check("wrr cnt_D1", bus.cnt_D1, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
